// File: rtl/layer_input_serializer_pkg.sv
// Shared sizing helpers, float-zero constant and the frame-boundary action
// encoding for the layer input serializer and its slot counter.
package layer_input_serializer_pkg;

  function automatic int unsigned word_w(input int unsigned bit_width,
                                         input int unsigned extra_bits);
    return bit_width + extra_bits;
  endfunction

  function automatic int unsigned frame_len(input int unsigned num_unknowns,
                                            input int unsigned num_nonlin);
    return num_unknowns + num_nonlin;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned frame_length);
    return (frame_length <= 1) ? 1 : $clog2(frame_length);
  endfunction

  // All-zero word is float zero with or without the two Flopoco exception bits.
  localparam logic FLOAT_ZERO_BIT = 1'b0;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_PROMOTE,
    ACT_BYPASS,
    ACT_CLEAR
  } active_op_e;

endpackage

// File: rtl/layer_input_serializer_if.sv
// Vector handshake in, serial scaler stream and frame/underrun status out.
interface layer_input_serializer_if
  import layer_input_serializer_pkg::*;
#(
  parameter int unsigned NUM_UNKNOWNS   = 2,
  parameter int unsigned NUM_NONLIN     = 1,
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned EXTRA_BITS     = 2,
  parameter int unsigned UNDERRUN_CNT_W = 8
) ();
  localparam int unsigned WORD_W    = word_w(BIT_WIDTH, EXTRA_BITS);
  localparam int unsigned FRAME_LEN = frame_len(NUM_UNKNOWNS, NUM_NONLIN);

  logic [WORD_W*FRAME_LEN-1:0] VEC_IN;
  logic                        VEC_VALID;
  logic                        VEC_READY;
  logic [WORD_W-1:0]           SCALER_OUT;
  logic                        SCALER_VALID;
  logic                        FRAME_START;
  logic                        FRAME_LAST;
  logic                        UNDERRUN;
  logic [UNDERRUN_CNT_W-1:0]   UNDERRUN_CNT;

  modport master (
    output VEC_IN, VEC_VALID,
    input  VEC_READY, SCALER_OUT, SCALER_VALID, FRAME_START, FRAME_LAST,
           UNDERRUN, UNDERRUN_CNT
  );

  modport slave (
    input  VEC_IN, VEC_VALID,
    output VEC_READY, SCALER_OUT, SCALER_VALID, FRAME_START, FRAME_LAST,
           UNDERRUN, UNDERRUN_CNT
  );
endinterface

// File: rtl/layer_input_serializer_frame_slot_counter.sv
// Free-running frame slot counter locked to the layer weight-pointer period.
module frame_slot_counter #(
  parameter int unsigned FRAME_LEN = 3,
  parameter int unsigned CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_start,
  output logic             frame_last,
  output logic             boundary
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CNT_W'(1);
  end

  assign frame_start = (cnt == '0);
  assign frame_last  = (cnt == LAST);
  // The edge that ends the last slot is where the next frame's owner is chosen.
  assign boundary    = frame_last;
endmodule

// File: rtl/layer_input_serializer.sv
// Parallel-vector to serial INPUT_SCALER stream with ACTIVE/PENDING double
// buffering; flagged zero frames cover gaps since the layer cannot stall.
module layer_input_serializer
  import layer_input_serializer_pkg::*;
#(
  parameter int unsigned NUM_UNKNOWNS   = 2,
  parameter int unsigned NUM_NONLIN     = 1,
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned EXTRA_BITS     = 2,
  parameter int unsigned UNDERRUN_CNT_W = 8
) (
  input logic                     CLK,
  input logic                     RESET,
  layer_input_serializer_if.slave bus
);
  localparam int unsigned WORD_W    = word_w(BIT_WIDTH, EXTRA_BITS);
  localparam int unsigned FRAME_LEN = frame_len(NUM_UNKNOWNS, NUM_NONLIN);
  localparam int unsigned CNT_W     = cnt_w(FRAME_LEN);

  typedef logic [FRAME_LEN-1:0][WORD_W-1:0] vec_t;

  logic [CNT_W-1:0]          cnt;
  logic                      frame_start;
  logic                      frame_last;
  logic                      boundary;
  vec_t                      active_vec;
  vec_t                      pend_vec;
  logic                      active_vld;
  logic                      pend_vld;
  logic                      started;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt;
  logic                      xfer;
  logic                      underrun;
  logic                      pend_load;
  active_op_e                active_op;

  frame_slot_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_slot (
    .clk         (CLK),
    .rst         (RESET),
    .cnt         (cnt),
    .frame_start (frame_start),
    .frame_last  (frame_last),
    .boundary    (boundary)
  );

  assign xfer = bus.VEC_VALID & ~pend_vld;

  // PENDING is always drained at a boundary, so a boundary transfer can only
  // happen with PENDING empty and goes straight into ACTIVE.
  always_comb begin
    active_op = ACT_HOLD;
    pend_load = 1'b0;
    if (boundary) begin
      if (pend_vld)  active_op = ACT_PROMOTE;
      else if (xfer) active_op = ACT_BYPASS;
      else           active_op = ACT_CLEAR;
    end else if (xfer) begin
      pend_load = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      active_vld <= 1'b0;
    end else begin
      unique case (active_op)
        ACT_PROMOTE: begin
          active_vec <= pend_vec;
          active_vld <= 1'b1;
        end
        ACT_BYPASS: begin
          active_vec <= vec_t'(bus.VEC_IN);
          active_vld <= 1'b1;
        end
        ACT_CLEAR: active_vld <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_vld <= 1'b0;
    end else if (pend_load) begin
      pend_vec <= vec_t'(bus.VEC_IN);
      pend_vld <= 1'b1;
    end else if (active_op == ACT_PROMOTE) begin
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)     started <= 1'b0;
    else if (xfer) started <= 1'b1;
  end

  assign underrun = started & frame_start & ~active_vld;

  always_ff @(posedge CLK) begin
    if (RESET)
      underrun_cnt <= '0;
    else if (underrun && (underrun_cnt != '1))
      underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
  end

  assign bus.VEC_READY    = ~pend_vld;
  assign bus.SCALER_OUT   = active_vld ? active_vec[cnt] : {WORD_W{FLOAT_ZERO_BIT}};
  assign bus.SCALER_VALID = active_vld;
  assign bus.FRAME_START  = frame_start;
  assign bus.FRAME_LAST   = frame_last;
  assign bus.UNDERRUN     = underrun;
  assign bus.UNDERRUN_CNT = underrun_cnt;
endmodule
